// File: rtl/peripheral_usart_tx_pkg.sv
// Shared definitions for the USART transmitter: default bus addresses,
// TXSTA bit positions, bit-time divisors and the transmit FSM encoding.
// The NINTH state only exists when USART_TX_NINTH_BIT_EN is defined.
package peripheral_usart_tx_pkg;

  // Default bus addresses of the three owned registers
  localparam logic [8:0] TXREG_ADDR_DEF = 9'h019;
  localparam logic [8:0] TXSTA_ADDR_DEF = 9'h098;
  localparam logic [8:0] SPBRG_ADDR_DEF = 9'h099;

  // TXSTA bit indices
  localparam int TXSTA_CSRC = 7;
  localparam int TXSTA_TX9  = 6;
  localparam int TXSTA_TXEN = 5;
  localparam int TXSTA_SYNC = 4;
  localparam int TXSTA_BRGH = 2;
  localparam int TXSTA_TRMT = 1;
  localparam int TXSTA_TX9D = 0;

  // Clocks per bit per (SPBRG+1), selected by BRGH
  localparam int BRGH_DIV_HI = 16;
  localparam int BRGH_DIV_LO = 64;

  // Bit-time counter width: (255+1)*64-1 still fits
  localparam int BAUD_CNT_W = 14;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
`ifdef USART_TX_NINTH_BIT_EN
    S_NINTH = 3'd3,
`endif
    S_STOP  = 3'd4
  } tx_state_e;

  // Reload value of the bit-time down-counter: one bit time minus one clock
  function automatic logic [BAUD_CNT_W-1:0] bit_period_m1(input logic [7:0] spbrg,
                                                         input logic       brgh);
    logic [BAUD_CNT_W:0] period;
    period = (15'(spbrg) + 15'd1) * (brgh ? 15'(BRGH_DIV_HI) : 15'(BRGH_DIV_LO));
    return BAUD_CNT_W'(period - 15'd1);
  endfunction

endpackage

// File: rtl/peripheral_usart_tx_baud_gen.sv
// Bit-time generator: a down-counter that restarts when a frame is loaded
// from idle and pulses o_bit_tick during the last clock of every bit time.
// The reload value is re-evaluated at every boundary, so SPBRG/BRGH edits
// take effect on the next bit.
module peripheral_usart_tx_baud_gen
  import peripheral_usart_tx_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i_spbrg,
  input  logic       i_brgh,
  input  logic       i_restart,
  output logic       o_bit_tick
);

  localparam logic [BAUD_CNT_W-1:0] CNT_ONE = 1;

  logic [BAUD_CNT_W-1:0] r_cnt;
  logic [BAUD_CNT_W-1:0] w_reload;

  assign w_reload   = bit_period_m1(i_spbrg, i_brgh);
  assign o_bit_tick = (r_cnt == '0) && !i_restart;

  // Count down one bit time; reload on restart or on reaching zero
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses <= so every register samples pre-edge values.
    if (rst) begin
      r_cnt <= '0;
    end else if (i_restart || (r_cnt == '0)) begin
      r_cnt <= w_reload;
    end else begin
      r_cnt <= r_cnt - CNT_ONE;
    end
  end

endmodule

// File: rtl/peripheral_usart_tx.sv
// Asynchronous USART transmitter on the core's external peripheral bus.
// Owns TXREG, TXSTA and SPBRG; serialises 8N1 frames LSB first on tx and
// drives txif (holding buffer empty while enabled).
// Optional feature macro: USART_TX_NINTH_BIT_EN adds TX9/TX9D and 9-bit frames.
module peripheral_usart_tx
  import peripheral_usart_tx_pkg::*;
#(
  parameter logic [8:0] TXREG_ADDR = TXREG_ADDR_DEF,
  parameter logic [8:0] TXSTA_ADDR = TXSTA_ADDR_DEF,
  parameter logic [8:0] SPBRG_ADDR = SPBRG_ADDR_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [8:0] extern_peripherals_addr,
  input  logic [7:0] extern_peripherals_data_in,
  input  logic       extern_peripherals_wr_en,
  output logic [7:0] extern_peripherals_data_out,
  output logic       tx,
  output logic       txif
);

  // Control/status registers
  logic       r_csrc;
  logic       r_txen;
  logic       r_txen_d;
  logic       r_sync;
  logic       r_brgh;
  logic       r_trmt;
  logic [7:0] r_spbrg;
  logic       w_tx9;
  logic       w_tx9d;

  // Holding buffer, shift register and FSM
  logic [7:0] r_txreg;
  logic       r_buf_full;
  logic [7:0] r_shift;
  logic [2:0] r_bit_cnt;
  logic       r_tx;
  tx_state_e  r_state;

  // Bus decode and frame control
  logic       w_wr_txreg;
  logic       w_wr_txsta;
  logic       w_wr_spbrg;
  logic       w_bit_tick;
  logic       w_restart;
  logic       w_load;
  logic [7:0] w_txsta;

  assign w_wr_txreg = extern_peripherals_wr_en && (extern_peripherals_addr == TXREG_ADDR);
  assign w_wr_txsta = extern_peripherals_wr_en && (extern_peripherals_addr == TXSTA_ADDR);
  assign w_wr_spbrg = extern_peripherals_wr_en && (extern_peripherals_addr == SPBRG_ADDR);

  // A frame starts from idle (counter restarted) or chains straight out of STOP
  assign w_restart = r_txen && r_buf_full && (r_state == S_IDLE);
  assign w_load    = w_restart || (r_txen && r_buf_full && (r_state == S_STOP) && w_bit_tick);

  assign tx   = r_tx;
  assign txif = r_txen && !r_buf_full;

`ifdef USART_TX_NINTH_BIT_EN
  logic r_tx9;
  logic r_tx9d;
  logic r_ninth_en;
  logic r_ninth_val;
  assign w_tx9  = r_tx9;
  assign w_tx9d = r_tx9d;
`else
  assign w_tx9  = 1'b0;
  assign w_tx9d = 1'b0;
`endif

  peripheral_usart_tx_baud_gen u_baud_gen (
    .clk       (clk),
    .rst       (rst),
    .i_spbrg   (r_spbrg),
    .i_brgh    (r_brgh),
    .i_restart (w_restart),
    .o_bit_tick(w_bit_tick)
  );

  // Software-writable TXSTA bits and the baud divisor
  always_ff @(posedge clk) begin
    if (rst) begin
      r_csrc  <= 1'b0;
      r_txen  <= 1'b0;
      r_sync  <= 1'b0;
      r_brgh  <= 1'b0;
      r_spbrg <= '0;
`ifdef USART_TX_NINTH_BIT_EN
      r_tx9   <= 1'b0;
      r_tx9d  <= 1'b0;
`endif
    end else begin
      if (w_wr_txsta) begin
        r_csrc <= extern_peripherals_data_in[TXSTA_CSRC];
        r_txen <= extern_peripherals_data_in[TXSTA_TXEN];
        r_sync <= extern_peripherals_data_in[TXSTA_SYNC];
        r_brgh <= extern_peripherals_data_in[TXSTA_BRGH];
`ifdef USART_TX_NINTH_BIT_EN
        r_tx9  <= extern_peripherals_data_in[TXSTA_TX9];
        r_tx9d <= extern_peripherals_data_in[TXSTA_TX9D];
`endif
      end
      if (w_wr_spbrg) begin
        r_spbrg <= extern_peripherals_data_in;
      end
    end
  end

  // Holding buffer: a core write always wins; a load or a TXEN 1->0 empties it
  always_ff @(posedge clk) begin
    // NOTE: the buffer byte is reset too, so a TXREG read after reset is defined.
    if (rst) begin
      r_txreg    <= '0;
      r_buf_full <= 1'b0;
      r_txen_d   <= 1'b0;
    end else begin
      r_txen_d <= r_txen;
      if (w_wr_txreg) begin
        r_txreg    <= extern_peripherals_data_in;
        r_buf_full <= 1'b1;
      end else if (w_load || (r_txen_d && !r_txen)) begin
        r_buf_full <= 1'b0;
      end
    end
  end

  // Transmit FSM: start, eight data bits LSB first, optional ninth, stop
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_tx        <= 1'b1;
      r_trmt      <= 1'b1;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
`ifdef USART_TX_NINTH_BIT_EN
      r_ninth_en  <= 1'b0;
      r_ninth_val <= 1'b0;
`endif
    end else if (!r_txen) begin
      r_state <= S_IDLE;
      r_tx    <= 1'b1;
      r_trmt  <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_buf_full) begin
            r_state     <= S_START;
            r_shift     <= r_txreg;
            r_tx        <= 1'b0;
            r_trmt      <= 1'b0;
`ifdef USART_TX_NINTH_BIT_EN
            r_ninth_en  <= w_tx9;
            r_ninth_val <= w_tx9d;
`endif
          end
        end
        S_START: begin
          if (w_bit_tick) begin
            r_state   <= S_DATA;
            r_tx      <= r_shift[0];
            r_shift   <= {1'b0, r_shift[7:1]};
            r_bit_cnt <= '0;
          end
        end
        S_DATA: begin
          if (w_bit_tick) begin
            if (r_bit_cnt == 3'd7) begin
`ifdef USART_TX_NINTH_BIT_EN
              if (r_ninth_en) begin
                r_state <= S_NINTH;
                r_tx    <= r_ninth_val;
              end else
`endif
              begin
                r_state <= S_STOP;
                r_tx    <= 1'b1;
              end
            end else begin
              r_tx      <= r_shift[0];
              r_shift   <= {1'b0, r_shift[7:1]};
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end
        end
`ifdef USART_TX_NINTH_BIT_EN
        S_NINTH: begin
          if (w_bit_tick) begin
            r_state <= S_STOP;
            r_tx    <= 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (w_bit_tick) begin
            if (r_buf_full) begin
              r_state     <= S_START;
              r_shift     <= r_txreg;
              r_tx        <= 1'b0;
`ifdef USART_TX_NINTH_BIT_EN
              r_ninth_en  <= w_tx9;
              r_ninth_val <= w_tx9d;
`endif
            end else begin
              r_state <= S_IDLE;
              r_trmt  <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
          r_trmt  <= 1'b1;
        end
      endcase
    end
  end

  // TXSTA read image with TRMT live and b3 fixed at 0
  always_comb begin
    w_txsta             = '0;
    w_txsta[TXSTA_CSRC] = r_csrc;
    w_txsta[TXSTA_TX9]  = w_tx9;
    w_txsta[TXSTA_TXEN] = r_txen;
    w_txsta[TXSTA_SYNC] = r_sync;
    w_txsta[TXSTA_BRGH] = r_brgh;
    w_txsta[TXSTA_TRMT] = r_trmt;
    w_txsta[TXSTA_TX9D] = w_tx9d;
  end

  // Combinational read mux; unowned addresses return zero
  always_comb begin
    // NOTE: default first so no path through this block leaves a latch.
    extern_peripherals_data_out = 8'h00;
    if (extern_peripherals_addr == TXREG_ADDR) begin
      extern_peripherals_data_out = r_txreg;
    end else if (extern_peripherals_addr == TXSTA_ADDR) begin
      extern_peripherals_data_out = w_txsta;
    end else if (extern_peripherals_addr == SPBRG_ADDR) begin
      extern_peripherals_data_out = r_spbrg;
    end
  end

endmodule

// File: tb/tb_peripheral_usart_tx.sv
// Directed + randomized bench for peripheral_usart_tx. Expected frames are
// built from the line protocol (start, data LSB first, optional ninth, stop)
// and bit times from (SPBRG+1)*16 or *64.
module tb_peripheral_usart_tx;

  localparam logic [8:0] A_TXREG = 9'h019;
  localparam logic [8:0] A_TXSTA = 9'h098;
  localparam logic [8:0] A_SPBRG = 9'h099;

  logic       clk;
  logic       rst;
  logic [8:0] addr;
  logic [7:0] wdata;
  logic       wr_en;
  logic [7:0] rdata;
  logic       tx;
  logic       txif;

  int checks = 0;
  int errors = 0;

  peripheral_usart_tx dut (
    .clk                        (clk),
    .rst                        (rst),
    .extern_peripherals_addr    (addr),
    .extern_peripherals_data_in (wdata),
    .extern_peripherals_wr_en   (wr_en),
    .extern_peripherals_data_out(rdata),
    .tx                         (tx),
    .txif                       (txif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [8:0] a, input logic [7:0] d);
    addr  = a;
    wdata = d;
    wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic bus_read(input logic [8:0] a, output logic [7:0] d);
    addr = a;
    #1;
    d = rdata;
  endtask

  function automatic int bit_time(input int spbrg, input bit brgh);
    return (spbrg + 1) * (brgh ? 16 : 64);
  endfunction

  // Wait for the start bit, then compare every clock of the frame against
  // the reference bit sequence. Optionally rewrites SPBRG during the start bit.
  task automatic check_frame(input string tag, input logic [7:0] data, input bit nine_en,
                             input bit nine_val, input int t_first, input int t_rest,
                             input int exp_lat, input int mid_spbrg);
    bit q[$];
    int lat;
    int bad;
    int dur;
    bit drv;
    lat = 0;
    while (tx !== 1'b0 && lat < 40) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    q.push_back(1'b0);
    for (int k = 0; k < 8; k++) q.push_back(data[k]);
    if (nine_en) q.push_back(nine_val);
    q.push_back(1'b1);
    for (int i = 0; i < q.size(); i++) begin
      dur = (i == 0) ? t_first : t_rest;
      bad = 0;
      for (int c = 0; c < dur; c++) begin
        if (tx !== q[i]) bad++;
        drv = (mid_spbrg >= 0) && (i == 0) && (c == 8);
        if (drv) begin
          addr  = A_SPBRG;
          wdata = 8'(mid_spbrg);
          wr_en = 1'b1;
        end
        tick();
        if (drv) wr_en = 1'b0;
      end
      check($sformatf("%s_bit%0d_bad_cycles", tag, i), 32'(bad), 32'd0);
    end
  endtask

  // Count clocks on which tx is not idle-high
  task automatic check_idle(input string tag, input int cycles);
    int bad;
    bad = 0;
    for (int c = 0; c < cycles; c++) begin
      if (tx !== 1'b1) bad++;
      tick();
    end
    check(tag, 32'(bad), 32'd0);
  endtask

  initial begin
    logic [7:0] rd;
    logic [7:0] b;
    int         s;

    rst   = 1'b1;
    addr  = '0;
    wdata = '0;
    wr_en = 1'b0;
    repeat (3) tick();
    check("tx_in_reset", 32'(tx), 32'd1);
    rst = 1'b0;
    tick();

    // Reset state
    bus_read(A_TXSTA, rd);
    check("txsta_reset", 32'(rd), 32'h02);
    bus_read(A_SPBRG, rd);
    check("spbrg_reset", 32'(rd), 32'h00);
    check("tx_reset", 32'(tx), 32'd1);
    check("txif_reset", 32'(txif), 32'd0);
    bus_read(9'h000, rd);
    check("unowned_000", 32'(rd), 32'h00);
    bus_read(9'h018, rd);
    check("unowned_018", 32'(rd), 32'h00);
    tick();

    // Basic 0x55 at 16 clk/bit
    bus_write(A_TXSTA, 8'h24);
    check("txif_enabled_empty", 32'(txif), 32'd1);
    bus_write(A_TXREG, 8'h55);
    check("txif_after_write", 32'(txif), 32'd0);
    check_frame("f55", 8'h55, 1'b0, 1'b0, 16, 16, 1, -1);
    bus_read(A_TXSTA, rd);
    check("trmt_after_f55", 32'(rd), 32'h26);
    bus_read(A_TXREG, rd);
    check("txreg_readback", 32'(rd), 32'h55);
    tick();

    // Back-to-back: second write lands on the load edge of the first
    bus_write(A_TXREG, 8'hA5);
    bus_write(A_TXREG, 8'h3C);
    check("txif_b2b_full", 32'(txif), 32'd0);
    bus_read(A_TXSTA, rd);
    check("trmt_busy", 32'(rd), 32'h24);
    check_frame("fA5", 8'hA5, 1'b0, 1'b0, 16, 16, 0, -1);
    check("txif_3c_loaded", 32'(txif), 32'd1);
    check_frame("f3C", 8'h3C, 1'b0, 1'b0, 16, 16, 0, -1);
    bus_read(A_TXSTA, rd);
    check("trmt_after_b2b", 32'(rd), 32'h26);
    check_idle("idle_after_b2b", 20);

    // Randomized bytes and divisors
    for (int n = 0; n < 3; n++) begin
      s = int'($urandom_range(0, 1));
      b = 8'($urandom);
      bus_write(A_SPBRG, 8'(s));
      bus_write(A_TXREG, b);
      check_frame($sformatf("rnd%0d", n), b, 1'b0, 1'b0, bit_time(s, 1'b1),
                  bit_time(s, 1'b1), 1, -1);
    end
    bus_write(A_SPBRG, 8'h00);

    // Disable mid-frame during data bit 3 with a second byte buffered
    bus_write(A_TXREG, 8'hF0);
    tick();
    bus_write(A_TXREG, 8'hC3);
    repeat (70) tick();
    check("abort_bit3_low", 32'(tx), 32'd0);
    bus_write(A_TXSTA, 8'h04);
    check("abort_txif", 32'(txif), 32'd0);
    tick();
    check("abort_tx_high", 32'(tx), 32'd1);
    bus_read(A_TXSTA, rd);
    check("abort_trmt", 32'(rd), 32'h06);
    check_idle("abort_stays_idle", 20);
    bus_write(A_TXSTA, 8'h24);
    check_idle("reenable_sends_nothing", 60);
    check("reenable_txif", 32'(txif), 32'd1);

    // Byte written while disabled is held until enabled
    bus_write(A_TXSTA, 8'h04);
    tick();
    bus_write(A_TXREG, 8'h81);
    check_idle("held_while_disabled", 40);
    bus_read(A_TXREG, rd);
    check("held_txreg", 32'(rd), 32'h81);
    check("held_txif", 32'(txif), 32'd0);
    bus_write(A_TXSTA, 8'h24);
    check_frame("f81", 8'h81, 1'b0, 1'b0, 16, 16, 1, -1);

    // Slow divisor, then a mid-frame SPBRG change
    b = 8'($urandom);
    bus_write(A_SPBRG, 8'h02);
    bus_write(A_TXSTA, 8'h20);
    bus_write(A_TXREG, b);
    check_frame("fslow", b, 1'b0, 1'b0, bit_time(2, 1'b0), bit_time(0, 1'b0), 1, 0);
    bus_read(A_SPBRG, rd);
    check("spbrg_mid_written", 32'(rd), 32'h00);

    // Ninth bit
`ifdef USART_TX_NINTH_BIT_EN
    bus_write(A_TXSTA, 8'h65);
    bus_read(A_TXSTA, rd);
    check("txsta_tx9", 32'(rd), 32'h67);
    tick();
    bus_write(A_TXREG, 8'h00);
    check_frame("f9", 8'h00, 1'b1, 1'b1, 16, 16, 1, -1);
`else
    bus_write(A_TXSTA, 8'h61);
    bus_read(A_TXSTA, rd);
    check("txsta_no_tx9", 32'(rd), 32'h22);
    tick();
`endif

    // Reset in the middle of a frame
    bus_write(A_TXSTA, 8'h24);
    bus_write(A_TXREG, 8'h00);
    repeat (40) tick();
    check("pre_rst_low", 32'(tx), 32'd0);
    rst = 1'b1;
    tick();
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_txif", 32'(txif), 32'd0);
    bus_read(A_TXSTA, rd);
    check("rst_txsta", 32'(rd), 32'h02);
    bus_read(A_SPBRG, rd);
    check("rst_spbrg", 32'(rd), 32'h00);
    tick();
    rst = 1'b0;
    check_idle("no_partial_frame", 50);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
